// File: rtl/multicycle_alu.sv
// Registered ALU with a start/busy/done handshake; MUL runs as an iterative shift-add
// taking WIDTH cycles, all other operations complete in a single cycle.
module multicycle_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags
);

    localparam int unsigned SHW  = $clog2(WIDTH);
    localparam int unsigned CntW = SHW + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpMul = 3'b101;
    localparam logic [2:0] OpLsl = 3'b110;
    localparam logic [2:0] OpLsr = 3'b111;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] ma_q, ma_d;
    logic [WIDTH-1:0] mb_q, mb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] acc_add;
    logic [CntW-1:0]  cnt_inc;

    // Single-cycle datapath; SUB reuses the adder with inverted b and carry-in.
    always_comb begin
        b_eff   = (ALUControl == OpSub) ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (ALUControl == OpSub)};
        shamt   = b[SHW-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUControl)
            OpAdd, OpSub: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OpAnd:   alu_res = a & b;
            OpOr:    alu_res = a | b;
            OpXor:   alu_res = a ^ b;
            OpLsl:   alu_res = a << shamt;
            OpLsr:   alu_res = a >> shamt;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        acc_add = mb_q[0] ? (acc_q + ma_q) : acc_q;
        cnt_inc = cnt_q + {{SHW{1'b0}}, 1'b1};
    end

    always_comb begin
        state_d  = state_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    if (ALUControl == OpMul) begin
                        ma_d    = a;
                        mb_d    = b;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = StMul;
                    end else begin
                        result_d = alu_res;
                        flags_d  = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
                        state_d  = StDone;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StMul: begin
                acc_d = acc_add;
                ma_d  = ma_q << 1;
                mb_d  = mb_q >> 1;
                cnt_d = cnt_inc;
                // Final iteration commits the accumulator including this cycle's add.
                if (cnt_inc == CntLast) begin
                    result_d = acc_add;
                    flags_d  = {acc_add[WIDTH-1], (acc_add == '0), 2'b00};
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            ma_q     <= '0;
            mb_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign busy     = (state_q == StMul);
    assign done     = (state_q == StDone);
    assign Result   = result_q;
    assign ALUFlags = flags_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: vector table for single-cycle ops, hand sequences for
// multiply latency, mid-multiply reset and back-to-back starts; results via scoreboard.
module tb_multicycle_alu;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   ALUControl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] Result;
    logic [3:0]   ALUFlags;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ALUControl (ALUControl),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .Result     (Result),
        .ALUFlags   (ALUFlags)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] res, input logic [3:0] flg);
        exp_t e;
        e.res = res;
        e.flg = flg;
        sb.push_back(e);
    endtask

    // Advance to the next falling edge and retire a result if done is high.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want no pending result");
            end else begin
                e = sb.pop_front();
                check("result", Result, e.res);
                check("flags", {28'b0, ALUFlags}, {28'b0, e.flg});
            end
        end
    endtask

    task automatic run_single(input vec_t v);
        ALUControl = v.op;
        a          = v.a;
        b          = v.b;
        start      = 1'b1;
        push(v.res, v.flg);
        tick();
        start = 1'b0;
        check("lat_done", {31'b0, done}, 32'd1);
        check("lat_busy", {31'b0, busy}, 32'd0);
        tick();
        check("done_pulse", {31'b0, done}, 32'd0);
        check("hold_result", Result, v.res);
    endtask

    task automatic run_mul(input logic [31:0] ma, input logic [31:0] mb,
                           input logic [31:0] res, input logic [3:0] flg, input bit disturb);
        int n;
        int g;
        ALUControl = 3'b101;
        a          = ma;
        b          = mb;
        start      = 1'b1;
        push(res, flg);
        tick();
        start = 1'b0;
        n = 0;
        g = 0;
        while (done !== 1'b1 && g < 100) begin
            if (busy === 1'b1) n++;
            g++;
            if (disturb) begin
                a          = $urandom;
                b          = $urandom;
                ALUControl = 3'($urandom_range(0, 7));
                start      = (g == 5);
            end
            tick();
        end
        start = 1'b0;
        if (g >= 100) begin
            total++;
            bad++;
            $display("FAIL mul_timeout: got no done within %0d cycles want done", g);
        end
        check("mul_busy_cycles", n, 32'd32);
        check("mul_busy_at_done", {31'b0, busy}, 32'd0);
        tick();
        check("mul_done_pulse", {31'b0, done}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110};
        vecs[1]  = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001};
        vecs[2]  = '{3'b001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 4'b1000};
        vecs[3]  = '{3'b001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
        vecs[4]  = '{3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110};
        vecs[5]  = '{3'b110, 32'h00000001, 32'd31,       32'h80000000, 4'b1000};
        vecs[6]  = '{3'b100, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 4'b0100};
        vecs[7]  = '{3'b110, 32'h12345678, 32'd32,       32'h12345678, 4'b0000};
        vecs[8]  = '{3'b111, 32'h80000000, 32'd31,       32'h00000001, 4'b0000};
        vecs[9]  = '{3'b010, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 4'b1000};
        vecs[10] = '{3'b011, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0100};
        vecs[11] = '{3'b000, 32'h00000003, 32'h00000004, 32'h00000007, 4'b0000};
        vecs[12] = '{3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 4'b0111};

        reset      = 1'b1;
        start      = 1'b0;
        ALUControl = 3'b000;
        a          = '0;
        b          = '0;
        repeat (2) tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", Result, 32'h0);
        check("rst_flags", {28'b0, ALUFlags}, 32'h0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) run_single(vecs[i]);

        run_mul(32'h00010003, 32'h00000005, 32'h0005000F, 4'b0000, 1'b1);
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 1'b0);
        run_mul(32'h40000000, 32'h00000002, 32'h80000000, 4'b1000, 1'b0);

        // Abort a multiply partway through; Result is nonzero beforehand.
        ALUControl = 3'b101;
        a          = 32'h00001234;
        b          = 32'h00000077;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("abort_busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_result", Result, 32'h0);
        check("abort_flags", {28'b0, ALUFlags}, 32'h0);
        reset = 1'b0;
        repeat (3) begin
            tick();
            check("abort_no_done", {31'b0, done}, 32'd0);
        end
        run_single('{3'b000, 32'h00000002, 32'h00000003, 32'h00000005, 4'b0000});

        // Start held high across three single-cycle ops.
        ALUControl = 3'b010;
        a          = 32'h0000F0F0;
        b          = 32'h0000FF00;
        start      = 1'b1;
        push(32'h0000F000, 4'b0000);
        tick();
        check("b2b_done0", {31'b0, done}, 32'd1);
        ALUControl = 3'b011;
        a          = 32'h00000001;
        b          = 32'h00000002;
        push(32'h00000003, 4'b0000);
        tick();
        check("b2b_done1", {31'b0, done}, 32'd1);
        ALUControl = 3'b111;
        a          = 32'h80000000;
        b          = 32'd33;
        push(32'h40000000, 4'b0000);
        tick();
        check("b2b_done2", {31'b0, done}, 32'd1);
        start = 1'b0;
        tick();
        check("b2b_end", {31'b0, done}, 32'd0);

        check("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
